// File: rtl/mem_stage.sv
// Pipeline MEM stage: runs loads and stores as little-endian byte-serial transfers on the
// dmem req/ack port, stalling the pipeline meanwhile; non-memory results pass straight through.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_mem_ce,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_mem_data,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic [7:0]  dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h22;
  localparam logic [7:0] OP_LBU = 8'h23;
  localparam logic [7:0] OP_LHU = 8'h24;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  op_r;
  logic [31:0] addr_r;
  logic [31:0] sdata_r;
  logic [31:0] asm_r;
  logic [1:0]  idx_r;
  logic        mem_op_s;
  logic        last_s;
  logic        xfer_s;

  function automatic logic is_mem_op(input logic ce, input logic [7:0] op);
    logic hit;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return ce && hit;
  endfunction

  function automatic logic is_load(input logic [7:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Index of the final byte of the transfer: 0, 1 or 3.
  function automatic logic [1:0] last_idx(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [7:0] op, input logic [31:0] v);
    case (op)
      OP_LB:   return {{24{v[7]}}, v[7:0]};
      OP_LH:   return {{16{v[15]}}, v[15:0]};
      OP_LBU:  return {24'd0, v[7:0]};
      OP_LHU:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign mem_op_s = is_mem_op(mem_mem_ce, mem_aluop);
  assign last_s   = (idx_r == last_idx(op_r));
  assign xfer_s   = (state_r == XFER);

  // The dmem port is decoded from registered state only, so ack never feeds back into req.
  assign dmem_req   = xfer_s;
  assign dmem_we    = xfer_s && !is_load(op_r);
  assign dmem_addr  = xfer_s ? (addr_r + {30'd0, idx_r}) : 32'd0;
  assign dmem_wdata = xfer_s ? sdata_r[{idx_r, 3'b000} +: 8] : 8'd0;

  // Next state plus writeback/stall outputs.
  always_comb begin
    state_nxt_s  = state_r;
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    stallreq_mem = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          state_nxt_s  = XFER;
          stallreq_mem = 1'b1;
          wb_wd        = 5'd0;
          wb_wreg      = 1'b0;
          wb_wdata     = 32'd0;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      XFER: begin
        if (dmem_ack && last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = XFER;
        end
        stallreq_mem = 1'b1;
        wb_wd        = 5'd0;
        wb_wreg      = 1'b0;
        wb_wdata     = 32'd0;
      end
      DONE: begin
        // The op still on the inputs here is the one just finished; never restart it.
        state_nxt_s = IDLE;
        if (is_load(op_r)) begin
          wb_wdata = extend(op_r, asm_r);
        end else begin
          wb_wdata = mem_wdata;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, latched request and load assembly register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      op_r    <= 8'd0;
      addr_r  <= 32'd0;
      sdata_r <= 32'd0;
      asm_r   <= 32'd0;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            op_r    <= mem_aluop;
            addr_r  <= mem_mem_addr;
            sdata_r <= mem_mem_data;
            asm_r   <= 32'd0;
            idx_r   <= 2'd0;
          end
        end
        XFER: begin
          if (dmem_ack) begin
            if (is_load(op_r)) begin
              asm_r[{idx_r, 3'b000} +: 8] <= dmem_rdata;
            end
            idx_r <= idx_r + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues ops and queues expected writeback and
// dmem byte transactions; a monitor and a memory responder pop and compare independently.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_mem_ce;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_mem_data;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        dmem_ack;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_aluop(mem_aluop), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_mem_ce(mem_mem_ce), .mem_mem_addr(mem_mem_addr), .mem_mem_data(mem_mem_data),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stallreq_mem(stallreq_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    bit          chk_data;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } byte_exp_t;

  wb_exp_t   wb_q[$];
  byte_exp_t byte_q[$];
  logic [7:0] mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int  errors = 0;
  int  checks = 0;
  int  ack_delay = 0;
  int  wait_cnt = 0;
  bit  op_live = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  function automatic bit is_mem(input logic ce, input logic [7:0] op);
    return ce && (op inside {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h28, 8'h29, 8'h2A});
  endfunction

  function automatic int nbytes(input logic [7:0] op);
    if (op inside {8'h20, 8'h23, 8'h28}) return 1;
    if (op inside {8'h21, 8'h24, 8'h29}) return 2;
    return 4;
  endfunction

  // Reference load: little-endian sum of bytes, then the sign/zero rule of the op.
  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < nbytes(op); k++) v = v | (32'(rd_ref(a + 32'(k))) << (8 * k));
    if (op == 8'h20 && v[7]) v = v | 32'hFFFF_FF00;
    if (op == 8'h21 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic issue(input logic [7:0] op, input logic ce, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] sdata, input int d);
    bit memop;
    bit store;
    int n;
    int cycles;
    logic [31:0] s;
    wb_exp_t e;
    @(negedge clk);
    mem_aluop = op; mem_mem_ce = ce; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_mem_addr = addr; mem_mem_data = sdata;
    ack_delay = d;
    op_live = 1'b1;
    memop = is_mem(ce, op);
    store = memop && (op inside {8'h28, 8'h29, 8'h2A});
    n = memop ? nbytes(op) : 0;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = !store;
    if (memop && !store) e.wdata = ref_load(op, addr);
    s = sdata;
    for (int k = 0; k < n; k++) begin
      byte_q.push_back('{we: store, addr: addr + 32'(k), wdata: store ? s[7:0] : 8'h00});
      if (store) ref_mem[addr + 32'(k)] = s[7:0];
      s = s >> 8;
    end
    wb_q.push_back(e);
    cycles = 0;
    #2;
    while (stallreq_mem && cycles < 200) begin
      cycles++;
      @(negedge clk);
      #2;
    end
    if (cycles >= 200) begin
      errors++;
      $display("FAIL timeout: op %h stalled beyond 200 cycles", op);
    end
    check32("stall_cycles", 32'(cycles), memop ? 32'(1 + n * (d + 1)) : 32'd0);
  endtask

  // Memory responder: checks every requested byte against the expected sequence, acks after the delay.
  initial begin
    byte_exp_t b;
    forever begin
      @(negedge clk);
      #1;
      dmem_ack = 1'b0;
      if (rst) begin
        wait_cnt = ack_delay;
      end else if (!dmem_req) begin
        wait_cnt = ack_delay;
        if ($urandom_range(0, 3) == 0) begin
          dmem_ack = 1'b1;
          dmem_rdata = 8'($urandom);
        end
      end else if (byte_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_req: addr %h with no byte expected", dmem_addr);
      end else begin
        b = byte_q[0];
        check32("dmem_addr", dmem_addr, b.addr);
        check32("dmem_we", 32'(dmem_we), 32'(b.we));
        if (b.we) check32("dmem_wdata", 32'(dmem_wdata), 32'(b.wdata));
        if (wait_cnt == 0) begin
          dmem_ack = 1'b1;
          dmem_rdata = rd_mem(dmem_addr);
          if (dmem_we) mem[dmem_addr] = dmem_wdata;
          void'(byte_q.pop_front());
          wait_cnt = ack_delay;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: bubbles while stalled; pops one expected writeback per completed op.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (stallreq_mem) begin
        check32("bubble_wreg", 32'(wb_wreg), 32'd0);
        check32("bubble_wd", 32'(wb_wd), 32'd0);
        check32("bubble_wdata", wb_wdata, 32'd0);
      end else if (op_live) begin
        check32("out_req", 32'(dmem_req), 32'd0);
        if (wb_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL wb_unexpected: output with empty scoreboard");
        end else begin
          e = wb_q.pop_front();
          check32("wb_wd", 32'(wb_wd), 32'(e.wd));
          check32("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
          if (e.chk_data) check32("wb_wdata", wb_wdata, e.wdata);
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    check32({tag, "_req"}, 32'(dmem_req), 32'd0);
    check32({tag, "_we"}, 32'(dmem_we), 32'd0);
    check32({tag, "_addr"}, dmem_addr, 32'd0);
    check32({tag, "_wdata"}, 32'(dmem_wdata), 32'd0);
    check32({tag, "_stall"}, 32'(stallreq_mem), 32'd0);
    check32({tag, "_wb"}, {wb_wdata[26:0], wb_wd}, 32'd0);
    check32({tag, "_wreg"}, 32'(wb_wreg), 32'd0);
  endtask

  task automatic zero_inputs();
    mem_aluop = 8'd0; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
    mem_mem_ce = 1'b0; mem_mem_addr = 32'd0; mem_mem_data = 32'd0;
  endtask

  initial begin
    logic [7:0] ops [8] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h28, 8'h29, 8'h2A};
    logic [7:0] op;
    logic [31:0] a;
    logic [31:0] sw_data;
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 8'h00;
    zero_inputs();
    set_byte(32'h100, 8'h11); set_byte(32'h101, 8'h22);
    set_byte(32'h102, 8'h33); set_byte(32'h103, 8'h44);
    set_byte(32'h110, 8'h80);
    set_byte(32'h120, 8'h34); set_byte(32'h121, 8'hF2);
    for (int i = 0; i < 64; i++) set_byte(32'h140 + 32'(i), 8'($urandom));
    repeat (3) @(negedge clk);
    #2;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    issue(8'h01, 1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 0);
    issue(8'h22, 1'b1, 5'd4, 1'b1, 32'h0, 32'h100, 32'h0, 0);
    issue(8'h20, 1'b1, 5'd6, 1'b1, 32'h0, 32'h110, 32'h0, 0);
    issue(8'h23, 1'b1, 5'd7, 1'b1, 32'h0, 32'h110, 32'h0, 1);
    issue(8'h21, 1'b1, 5'd8, 1'b1, 32'h0, 32'h120, 32'h0, 0);
    issue(8'h29, 1'b1, 5'd0, 1'b0, 32'h0, 32'h203, 32'h0000ABCD, 3);
    check32("sh_byte0", 32'(rd_mem(32'h203)), 32'h0000_00CD);
    check32("sh_byte1", 32'(rd_mem(32'h204)), 32'h0000_00AB);
    sw_data = $urandom;
    issue(8'h2A, 1'b1, 5'd0, 1'b0, 32'h0, 32'h150, sw_data, 0);
    issue(8'h22, 1'b1, 5'd9, 1'b1, 32'h0, 32'h150, 32'h0, 0);

    // Reset in the middle of an LW, after its first byte has been acked.
    @(negedge clk);
    op_live = 1'b0;
    mem_aluop = 8'h22; mem_mem_ce = 1'b1; mem_wd = 5'd3; mem_wreg = 1'b1;
    mem_mem_addr = 32'h300; mem_mem_data = 32'h0;
    ack_delay = 0;
    byte_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 8'h00});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    zero_inputs();
    @(negedge clk);
    #2;
    reset_checks("midreset");
    rst = 1'b0;
    issue(8'h20, 1'b1, 5'd10, 1'b1, 32'h0, 32'h110, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
      a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'h140 + 32'($urandom_range(0, 63));
      if (op inside {8'h28, 8'h29, 8'h2A})
        issue(op, 1'($urandom_range(0, 7) != 0), 5'd0, 1'b0, $urandom, a, $urandom,
              $urandom_range(0, 2));
      else
        issue(op, 1'($urandom_range(0, 7) != 0), 5'($urandom), 1'($urandom), $urandom, a,
              $urandom, $urandom_range(0, 2));
    end

    @(negedge clk);
    op_live = 1'b0;
    zero_inputs();
    repeat (3) @(negedge clk);
    check32("wb_q_empty", 32'(wb_q.size()), 32'd0);
    check32("byte_q_empty", 32'(byte_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX/MEM register and upstream of the MEM/WB register.
- Executes loads and stores over a byte-serial req/ack data-memory port, one byte per handshake, little-endian.
- Holds the pipeline through the ctrl stall request while a transfer is in flight.
- Passes non-memory results through to writeback unchanged.

Parameters:
- None. Widths come from defines.v: RegBus 32, RegAddrBus 5, AluOpBus 8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- mem_aluop  in  8  op from EX/MEM
- mem_wd  in  5  destination register
- mem_wreg  in  1  register write enable
- mem_wdata  in  32  ALU result
- mem_mem_ce  in  1  memory access valid
- mem_mem_addr  in  32  byte address
- mem_mem_data  in  32  store data
- wb_wd  out  5  to MEM/WB
- wb_wreg  out  1  to MEM/WB
- wb_wdata  out  32  to MEM/WB
- stallreq_mem  out  1  to ctrl; high means freeze stages 0..4
- dmem_req  out  1  byte request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address
- dmem_wdata  out  8  write byte
- dmem_rdata  in  8  read byte, valid while dmem_ack is high
- dmem_ack  in  1  handshake complete

Behaviour:
- Op codes: LB 8'h20, LH 8'h21, LW 8'h22, LBU 8'h23, LHU 8'h24, SB 8'h28, SH 8'h29, SW 8'h2A.
- A memory op requires mem_mem_ce=1 and aluop in that set. Any other combination is a pass-through.
- Byte count: 1 for B/BU, 2 for H/HU, 4 for W. No alignment check; bytes come from addr, addr+1, ... (wrap modulo 2^32).
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - Pass-through: wb_* = mem_* combinationally; stallreq_mem=0.
  - Memory op: stallreq_mem=1 combinationally. Next edge latches op, addr, store data; clears byte index and assembly register; goes to XFER.
- XFER:
  - dmem_req=1. dmem_we=1 for stores.
  - dmem_addr = latched addr + idx. dmem_wdata = store data byte[idx].
  - On each edge with req&&ack: loads write dmem_rdata into assembly byte[idx]; idx increments.
  - Ack of the last byte moves to DONE. With no ack, all dmem outputs hold; there is no timeout.
  - stallreq_mem=1 throughout.
- DONE:
  - dmem_req=0, stallreq_mem=0.
  - Loads: wb_wdata = assembled value, extended:
    - LB: sign-extend bit 7.
    - LH: sign-extend bit 15.
    - LBU/LHU: zero-extend.
    - LW: as assembled.
  - wb_wd/wb_wreg = mem_wd/mem_wreg. Stores: wb_wreg = mem_wreg (0 from decode).
  - Next edge always goes to IDLE. The op still present on the inputs in DONE is never re-issued.
- While in IDLE-with-memory-op or XFER: wb_wreg=0, wb_wd=0, wb_wdata=0. This is a bubble; MEM/WB is held by ctrl anyway.
- dmem_rdata is ignored unless a load is in XFER with ack high. An ack while req is low is ignored.
- Minimum latency with ack every cycle: 1 (IDLE) + N (XFER) + 1 (DONE) cycles; LW occupies 6 cycles.
- Reset (any state, including mid-XFER):
  - State goes to IDLE; idx, latches and assembly register go to 0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, stallreq_mem=0.
  - wb_* follow pass-through of the inputs (the upstream register is also in reset: wd=0, wreg=0, wdata=0).
- dmem_* outputs are decoded from registered state only; no combinational path from dmem_ack to dmem_req.

Test Plan:
- Pass-through: aluop=8'h01, ce=0, wd=5, wreg=1, wdata=32'hDEADBEEF → same cycle wb_wd=5, wb_wreg=1, wb_wdata=32'hDEADBEEF, stallreq_mem=0, dmem_req=0.
- LW, addr 32'h100, ack every cycle, memory 0x100..0x103 = 11,22,33,44 →
  - dmem_addr sequence 0x100..0x103.
  - stallreq_mem high for 5 cycles.
  - DONE cycle: wb_wdata=32'h44332211, wb_wreg=1.
- LB vs LBU at a byte of 8'h80 → wb_wdata=32'hFFFFFF80 for LB, 32'h00000080 for LBU. LH of bytes 8'h34,8'hF2 → 32'hFFFFF234.
- SH, addr 32'h203, data 32'h0000ABCD, ack delayed 3 cycles per byte →
  - Writes 8'hCD to 0x203, then 8'hAB to 0x204.
  - dmem_req/addr/wdata stable while waiting for ack.
  - wb_wreg=0 throughout.
  - Exactly 2 acks consumed.
- Back-to-back: SW immediately followed by LW (inputs change the cycle after DONE) → second op starts cleanly, no duplicate SW bytes, idx restarts at 0.
- Reset asserted in XFER after the first of 4 LW bytes → next cycle dmem_req=0, stallreq_mem=0, state IDLE. Subsequent LB completes correctly.
